div16x8_approx_seq: RTL and testbench



---
 rtl/div16x8_approx_seq.sv | 109 ++++++++++
 tb/tb_div16x8_approx_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div16x8_approx_seq.sv
// Iterative radix-2 restoring divider, 16-bit dividend by 8-bit divisor, one quotient bit per cycle.
// The low APPROX_LSB quotient bits are not computed, trading accuracy for latency.
module div16x8_approx_seq #(
    parameter int APPROX_LSB = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);

    localparam int          N        = 16 - APPROX_LSB;
    localparam logic [4:0]  N_CNT    = 5'(N);
    localparam logic [15:0] LOW_MASK = 16'((32'd1 << APPROX_LSB) - 32'd1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  count;
    logic [7:0]  rem_r;
    logic [15:0] shift_r;
    logic [15:0] q_acc;
    logic [15:0] dividend_r;
    logic [7:0]  divisor_r;

    logic        accept;
    logic [8:0]  trial;
    logic [8:0]  trial_diff;
    logic        trial_ge;
    logic [7:0]  rem_next;
    logic [15:0] q_next;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds its results until taken.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // R stays below the divisor, so the 9-bit trial difference always fits back into 8 bits.
    assign trial      = {rem_r, shift_r[15]};
    assign trial_diff = trial - {1'b0, divisor_r};
    assign trial_ge   = (trial >= {1'b0, divisor_r});
    assign rem_next   = trial_ge ? trial_diff[7:0] : trial[7:0];
    assign q_next     = {q_acc[14:0], trial_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (divisor == 8'd0) ? DONE : RUN;
            RUN:  if (count == 5'd1) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= 5'd0;
            rem_r       <= 8'd0;
            shift_r     <= 16'd0;
            q_acc       <= 16'd0;
            dividend_r  <= 16'd0;
            divisor_r   <= 8'd0;
            quotient    <= 16'd0;
            remainder   <= 16'd0;
            div_by_zero <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                dividend_r <= dividend;
                divisor_r  <= divisor;
                if (divisor == 8'd0) begin
                    quotient    <= 16'hFFFF;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                    count       <= 5'd0;
                end else begin
                    rem_r   <= 8'd0;
                    shift_r <= dividend;
                    q_acc   <= 16'd0;
                    count   <= N_CNT;
                end
            end
        end else if (state == RUN) begin
            rem_r   <= rem_next;
            shift_r <= {shift_r[14:0], 1'b0};
            q_acc   <= q_next;
            count   <= count - 5'd1;
            if (count == 5'd1) begin
                // Skipped dividend bits pass straight into the residual below the partial remainder.
                quotient    <= q_next << APPROX_LSB;
                remainder   <= ({8'h00, rem_next} << APPROX_LSB) | (dividend_r & LOW_MASK);
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div16x8_approx_seq.sv
// Directed and randomized bench for div16x8_approx_seq, exact (APPROX_LSB=0) and truncated (APPROX_LSB=4).
module tb_div16x8_approx_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, out_ready, use4;
    logic [15:0] dividend;
    logic [7:0]  divisor;

    logic        in_valid0, in_ready0, out_valid0, out_ready0, dbz0;
    logic [15:0] quotient0, remainder0;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, dbz4;
    logic [15:0] quotient4, remainder4;

    logic        in_ready_m, out_valid_m, dbz_m;
    logic [15:0] quotient_m, remainder_m;

    assign in_valid0   = in_valid & ~use4;
    assign out_ready0  = out_ready & ~use4;
    assign in_valid4   = in_valid & use4;
    assign out_ready4  = out_ready & use4;
    assign in_ready_m  = use4 ? in_ready4   : in_ready0;
    assign out_valid_m = use4 ? out_valid4  : out_valid0;
    assign quotient_m  = use4 ? quotient4   : quotient0;
    assign remainder_m = use4 ? remainder4  : remainder0;
    assign dbz_m       = use4 ? dbz4        : dbz0;

    div16x8_approx_seq #(.APPROX_LSB(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .quotient(quotient0), .remainder(remainder0), .div_by_zero(dbz0)
    );

    div16x8_approx_seq #(.APPROX_LSB(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .quotient(quotient4), .remainder(remainder4), .div_by_zero(dbz4)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Reference: the first 16-a dividend bits are divided exactly, the rest pass through.
    function automatic void model(input logic [15:0] d, input logic [7:0] v, input int a,
                                  output logic [15:0] q, output logic [15:0] r, output logic z);
        int hi;
        int lo;
        if (v == 8'd0) begin
            q = 16'hFFFF;
            r = d;
            z = 1'b1;
        end else begin
            hi = int'(d) >> a;
            lo = int'(d) % (1 << a);
            q  = 16'((hi / int'(v)) << a);
            r  = 16'(((hi % int'(v)) << a) | lo);
            z  = 1'b0;
        end
    endfunction

    task automatic start_op(input logic [15:0] d, input logic [7:0] v);
        int guard = 0;
        while (!in_ready_m && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_accept", 32'(in_ready_m), 32'd1);
        in_valid = 1'b1;
        dividend = d;
        divisor  = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int exp_lat, output logic [15:0] q, output logic [15:0] r,
                               output logic z);
        int lat = 0;
        while (!out_valid_m && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        q = quotient_m;
        r = remainder_m;
        z = dbz_m;
    endtask

    task automatic handoff(input int hold, input bit rand_ready);
        logic [15:0] q_hold, r_hold;
        logic        z_hold;
        int          guard = 0;
        q_hold = quotient_m;
        r_hold = remainder_m;
        z_hold = dbz_m;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid_m), 32'd1);
            check("hold_in_ready", 32'(in_ready_m), 32'd0);
            check("hold_q", 32'(quotient_m), 32'(q_hold));
            check("hold_r", 32'(remainder_m), 32'(r_hold));
            check("hold_z", 32'(dbz_m), 32'(z_hold));
        end
        do begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            guard++;
            if (out_valid_m && (quotient_m !== q_hold || remainder_m !== r_hold))
                check("rand_hold_stable", {quotient_m, remainder_m}, {q_hold, r_hold});
        end while (out_valid_m && guard < 60);
        out_ready = 1'b0;
        check("handoff_valid_low", 32'(out_valid_m), 32'd0);
        check("handoff_in_ready", 32'(in_ready_m), 32'd1);
    endtask

    task automatic run_op(input logic [15:0] d, input logic [7:0] v, input int hold,
                          input bit rand_ready, output logic [15:0] q, output logic [15:0] r,
                          output logic z);
        logic [15:0] eq, er;
        logic        ez;
        int          a;
        a = use4 ? 4 : 0;
        model(d, v, a, eq, er, ez);
        start_op(d, v);
        wait_result((v == 8'd0) ? 0 : 16 - a, q, r, z);
        check("quotient", 32'(q), 32'(eq));
        check("remainder", 32'(r), 32'(er));
        check("div_by_zero", 32'(z), 32'(ez));
        if (v != 8'd0) begin
            check("invariant", 32'(q) * 32'(v) + 32'(r), 32'(d));
            check("rem_bound", 32'(32'(r) < (32'(v) << a)), 32'd1);
            if (a == 0) begin
                check("exact_q", 32'(q), 32'(d / 16'(v)));
                check("exact_r", 32'(r), 32'(d % 16'(v)));
            end
        end
        handoff(hold, rand_ready);
    endtask

    initial begin
        logic [15:0] q, r, bq, br;
        logic        z, bz;
        int          seen;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        use4      = 1'b0;
        dividend  = 16'd0;
        divisor   = 8'd0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            use4 = s[0];
            #1;
            check("rst_in_ready", 32'(in_ready_m), 32'd1);
            check("rst_out_valid", 32'(out_valid_m), 32'd0);
            check("rst_quotient", 32'(quotient_m), 32'd0);
            check("rst_remainder", 32'(remainder_m), 32'd0);
            check("rst_dbz", 32'(dbz_m), 32'd0);
        end
        use4 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'd1000, 8'd7, 2, 1'b0, q, r, z);
        check("t1000_7_q", 32'(q), 32'd142);
        check("t1000_7_r", 32'(r), 32'd6);
        run_op(16'd65535, 8'd1, 0, 1'b0, q, r, z);
        check("tmax_1_q", 32'(q), 32'd65535);
        check("tmax_1_r", 32'(r), 32'd0);
        run_op(16'd65535, 8'd255, 0, 1'b0, q, r, z);
        check("tmax_255_q", 32'(q), 32'd257);
        check("tmax_255_r", 32'(r), 32'd0);
        run_op(16'd5, 8'd200, 0, 1'b0, q, r, z);
        check("t5_200_q", 32'(q), 32'd0);
        check("t5_200_r", 32'(r), 32'd5);

        run_op(16'd1234, 8'd0, 1, 1'b0, q, r, z);
        check("tzero_q", 32'(q), 32'hFFFF);
        check("tzero_r", 32'(r), 32'd1234);
        check("tzero_z", 32'(z), 32'd1);
        run_op(16'd1000, 8'd7, 0, 1'b0, q, r, z);
        check("after_zero_z", 32'(z), 32'd0);

        // Backpressure with in_valid held high and operands changing every cycle.
        start_op(16'd1000, 8'd7);
        wait_result(16, bq, br, bz);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dividend = 16'($urandom_range(0, 65535));
            divisor  = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid_m), 32'd1);
            check("bp_in_ready", 32'(in_ready_m), 32'd0);
            check("bp_q", 32'(quotient_m), 32'd142);
            check("bp_r", 32'(remainder_m), 32'd6);
        end
        dividend  = 16'd300;
        divisor   = 8'd9;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_handoff_valid", 32'(out_valid_m), 32'd0);
        check("bp_handoff_in_ready", 32'(in_ready_m), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_accepted", 32'(in_ready_m), 32'd0);
        wait_result(16, q, r, z);
        check("bp_next_q", 32'(q), 32'd33);
        check("bp_next_r", 32'(r), 32'd3);
        handoff(0, 1'b0);

        // Reset pulse in the fifth RUN cycle aborts with nothing emitted.
        start_op(16'd1000, 8'd7);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid_m), 32'd0);
        check("midrst_in_ready", 32'(in_ready_m), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid_m) seen++;
        end
        check("midrst_no_output", 32'(seen), 32'd0);
        run_op(16'd300, 8'd9, 0, 1'b0, q, r, z);
        check("post_rst_q", 32'(q), 32'd33);
        check("post_rst_r", 32'(r), 32'd3);

        for (int i = 0; i < 2000; i++) begin
            run_op(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), 0, 1'b1, q, r, z);
        end

        use4 = 1'b1;
        #1;
        run_op(16'd1000, 8'd7, 0, 1'b0, q, r, z);
        check("a4_1000_7_q", 32'(q), 32'd128);
        check("a4_1000_7_r", 32'(r), 32'd104);
        for (int i = 0; i < 300; i++) begin
            run_op(16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), 0, 1'b1, q, r, z);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
